// File: rtl/dircc_proc_mem_pkg.sv
// Shared widths and the master-index type for the dual-master port-2 memory arbiter.
package dircc_proc_mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef logic master_idx_t;

endpackage

// File: rtl/dircc_rr_arbiter2.sv
// Two-way round-robin grant: the master that did not win last time gets priority on a conflict.
module dircc_rr_arbiter2
    import dircc_proc_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        hold,
    output logic        accept,
    output master_idx_t grant_idx
);

    master_idx_t last_grant;

    always_comb begin
        grant_idx = 1'b0;
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else if (req1) begin
            grant_idx = 1'b1;
        end
        // Nothing is accepted while the memory clock is held off or the block is in reset.
        accept = (req0 | req1) & ~hold & reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/dircc_proc_mem_port2_arbiter.sv
// Arbitrates two Avalon-style masters onto one single-port memory with 1-cycle read latency.
module dircc_proc_mem_port2_arbiter
    import dircc_proc_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = BE_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic        req0;
    logic        req1;
    logic        accept;
    logic        sel_write;
    master_idx_t grant_idx;
    logic        rd_pending;
    master_idx_t rd_owner;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign mem_clken = ~reset_req;

    dircc_rr_arbiter2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .hold      (reset_req),
        .accept    (accept),
        .grant_idx (grant_idx)
    );

    always_comb begin
        // A master asserting both read and write is treated as writing.
        sel_write      = grant_idx ? m1_write : m0_write;
        mem_chipselect = accept;
        mem_write      = accept & sel_write;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        if (accept) begin
            mem_address    = grant_idx ? m1_address    : m0_address;
            mem_writedata  = grant_idx ? m1_writedata  : m0_writedata;
            mem_byteenable = grant_idx ? m1_byteenable : m0_byteenable;
        end
        m0_waitrequest   = req0 & ~(accept & (grant_idx == 1'b0));
        m1_waitrequest   = req1 & ~(accept & (grant_idx == 1'b1));
        m0_readdatavalid = rd_pending & (rd_owner == 1'b0);
        m1_readdatavalid = rd_pending & (rd_owner == 1'b1);
        m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
        m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= accept & ~sel_write;
            if (accept && !sel_write) begin
                rd_owner <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_dircc_proc_mem_port2_arbiter.sv
// Directed bench for the port-2 arbiter with a small single-port memory model behind it.
module tb_dircc_proc_mem_port2_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset_req;
    logic [13:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [13:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_readdata;

    int n_cmp = 0;
    int n_bad = 0;
    int g0, g1;

    always #5 clk = ~clk;

    dircc_proc_mem_port2_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .reset_req        (reset_req),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_byteenable   (mem_byteenable),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Memory model: registered address, unregistered q; preloaded with 0xA000+addr while in reset.
    logic [15:0] mem_model [0:63];
    logic [15:0] q_reg;
    assign mem_readdata = q_reg;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem_model[i] <= 16'hA000 + 16'(i);
            q_reg <= 16'h0000;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                if (mem_byteenable[0]) mem_model[mem_address[5:0]][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) mem_model[mem_address[5:0]][15:8] <= mem_writedata[15:8];
            end else begin
                q_reg <= mem_model[mem_address[5:0]];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [13:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        m0_read = r; m0_write = w; m0_address = a; m0_writedata = d; m0_byteenable = b;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [13:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        m1_read = r; m1_write = w; m1_address = a; m1_writedata = d; m1_byteenable = b;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_req = 1'b0;
        idle();
        set_m0(1'b1, 1'b0, 14'h0001, 16'h0, 2'b00);

        // In reset: requests still see waitrequest, nothing is issued
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cs",      32'(mem_chipselect),   32'h0);
        check_val("rst_memwr",   32'(mem_write),        32'h0);
        check_val("rst_m0_wait", 32'(m0_waitrequest),   32'h1);
        check_val("rst_m0_rdv",  32'(m0_readdatavalid), 32'h0);
        check_val("rst_m1_rd",   32'(m1_readdata),      32'h0);
        check_val("rst_clken",   32'(mem_clken),        32'h1);

        // Simultaneous reads right after reset: m0 wins first
        next_cycle();
        reset_n = 1'b1;
        set_m0(1'b1, 1'b0, 14'h0001, 16'h0, 2'b00);
        set_m1(1'b1, 1'b0, 14'h0002, 16'h0, 2'b00);
        @(negedge clk);
        check_val("c0_m0_wait", 32'(m0_waitrequest), 32'h0);
        check_val("c0_m1_wait", 32'(m1_waitrequest), 32'h1);
        check_val("c0_addr",    32'(mem_address),    32'h0001);
        next_cycle();
        set_m0(1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
        @(negedge clk);
        check_val("c1_m1_wait", 32'(m1_waitrequest),   32'h0);
        check_val("c1_addr",    32'(mem_address),      32'h0002);
        check_val("c1_m0_rdv",  32'(m0_readdatavalid), 32'h1);
        check_val("c1_m0_rd",   32'(m0_readdata),      32'hA001);
        check_val("c1_m1_rdv",  32'(m1_readdatavalid), 32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check_val("c2_m1_rdv", 32'(m1_readdatavalid), 32'h1);
        check_val("c2_m1_rd",  32'(m1_readdata),      32'hA002);
        check_val("c2_m0_rdv", 32'(m0_readdatavalid), 32'h0);
        check_val("c2_m0_rd",  32'(m0_readdata),      32'h0);

        // Single master write then read of 0x0010
        next_cycle();
        set_m0(1'b0, 1'b1, 14'h0010, 16'hBEEF, 2'b11);
        @(negedge clk);
        check_val("w_m0_wait", 32'(m0_waitrequest), 32'h0);
        check_val("w_cs",      32'(mem_chipselect), 32'h1);
        check_val("w_memwr",   32'(mem_write),      32'h1);
        check_val("w_addr",    32'(mem_address),    32'h0010);
        check_val("w_data",    32'(mem_writedata),  32'hBEEF);
        next_cycle();
        set_m0(1'b1, 1'b0, 14'h0010, 16'h0, 2'b00);
        @(negedge clk);
        check_val("r_m0_wait", 32'(m0_waitrequest), 32'h0);
        check_val("r_memwr",   32'(mem_write),      32'h0);
        check_val("r_wdata",   32'(mem_writedata),  32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check_val("r_m0_rdv", 32'(m0_readdatavalid), 32'h1);
        check_val("r_m0_rd",  32'(m0_readdata),      32'hBEEF);
        check_val("r_m1_rd",  32'(m1_readdata),      32'h0);
        check_val("idle_cs",  32'(mem_chipselect),   32'h0);
        check_val("idle_addr", 32'(mem_address),     32'h0);

        // Byte write over 0xFFFF, then read back in the very next cycle
        next_cycle();
        set_m1(1'b0, 1'b1, 14'h0020, 16'hFFFF, 2'b11);
        next_cycle();
        set_m1(1'b0, 1'b1, 14'h0020, 16'h1234, 2'b01);
        @(negedge clk);
        check_val("bw_be", 32'(mem_byteenable), 32'h1);
        next_cycle();
        set_m1(1'b1, 1'b0, 14'h0020, 16'h0, 2'b00);
        next_cycle();
        idle();
        @(negedge clk);
        check_val("bw_m1_rdv", 32'(m1_readdatavalid), 32'h1);
        check_val("bw_m1_rd",  32'(m1_readdata),      32'hFF34);

        // Continuous conflict for 8 cycles: strict alternation starting with m0
        next_cycle();
        set_m0(1'b1, 1'b0, 14'h0003, 16'h0, 2'b00);
        set_m1(1'b1, 1'b0, 14'h0004, 16'h0, 2'b00);
        g0 = 0;
        g1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val($sformatf("rr_wait_%0d", k), {30'h0, m1_waitrequest, m0_waitrequest},
                      (k % 2 == 0) ? 32'h2 : 32'h1);
            if (!m0_waitrequest) g0++;
            if (!m1_waitrequest) g1++;
            next_cycle();
        end
        check_val("rr_cnt0", 32'(g0), 32'd4);
        check_val("rr_cnt1", 32'(g1), 32'd4);

        // Read accepted just before a 3-cycle hold-off still completes
        set_m0(1'b1, 1'b0, 14'h0001, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
        next_cycle();
        reset_req = 1'b1;
        set_m1(1'b1, 1'b0, 14'h0004, 16'h0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val($sformatf("ho_clken_%0d", k), 32'(mem_clken),      32'h0);
            check_val($sformatf("ho_cs_%0d", k),    32'(mem_chipselect), 32'h0);
            check_val($sformatf("ho_wait_%0d", k),  {30'h0, m1_waitrequest, m0_waitrequest}, 32'h3);
            check_val($sformatf("ho_rdv_%0d", k),   32'(m0_readdatavalid), (k == 0) ? 32'h1 : 32'h0);
            if (k == 0) check_val("ho_rd", 32'(m0_readdata), 32'hA001);
            next_cycle();
        end
        reset_req = 1'b0;
        @(negedge clk);
        check_val("post_ho_m1_wait", 32'(m1_waitrequest), 32'h0);
        check_val("post_ho_m0_wait", 32'(m0_waitrequest), 32'h1);
        next_cycle();
        set_m1(1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
        @(negedge clk);
        check_val("starve_m0_wait", 32'(m0_waitrequest),   32'h0);
        check_val("starve_m1_rdv",  32'(m1_readdatavalid), 32'h1);
        check_val("starve_m1_rd",   32'(m1_readdata),      32'hA004);

        // Reset with a read pending drops it; m0 wins the first conflict afterwards
        next_cycle();
        set_m0(1'b1, 1'b0, 14'h0005, 16'h0, 2'b00);
        next_cycle();
        reset_n = 1'b0;
        idle();
        set_m1(1'b0, 1'b1, 14'h0006, 16'h5555, 2'b11);
        @(negedge clk);
        check_val("rp_m0_rdv",  32'(m0_readdatavalid), 32'h0);
        check_val("rp_m0_rd",   32'(m0_readdata),      32'h0);
        check_val("rp_m1_wait", 32'(m1_waitrequest),   32'h1);
        check_val("rp_memwr",   32'(mem_write),        32'h0);
        next_cycle();
        reset_n = 1'b1;
        idle();
        @(negedge clk);
        check_val("rel_m0_rdv", 32'(m0_readdatavalid), 32'h0);
        check_val("rel_m1_rdv", 32'(m1_readdatavalid), 32'h0);
        next_cycle();
        set_m0(1'b0, 1'b1, 14'h0007, 16'h1111, 2'b11);
        set_m1(1'b0, 1'b1, 14'h0008, 16'h2222, 2'b11);
        @(negedge clk);
        check_val("rel_m0_wait", 32'(m0_waitrequest), 32'h0);
        check_val("rel_m1_wait", 32'(m1_waitrequest), 32'h1);
        check_val("rel_wdata",   32'(mem_writedata),  32'h1111);
        next_cycle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dircc_proc_mem_port2_arbiter.md
DIRCC_PROC_MEM_PORT2_ARBITER -- requirements
Module: dircc_proc_mem_port2_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, port-2 word address width (16-bit words).
REQ-002 The block SHALL have parameter DATA_W, default 16, port-2 data width.
REQ-003 The block SHALL have parameter BE_W, default 2, byte-enable width, equal to DATA_W/8.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, shared with the memory's clock0.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port reset_req, input, 1 bit: memory clock-enable hold-off request.
REQ-008 For N in {0,1}, the block SHALL have these master ports:
- mN_address, input, ADDR_W
- mN_read, input, 1
- mN_write, input, 1
- mN_writedata, input, DATA_W
- mN_byteenable, input, BE_W
REQ-009 For N in {0,1}, the block SHALL have these outputs: mN_waitrequest (1), mN_readdata (DATA_W), mN_readdatavalid (1).
REQ-010 The block SHALL have these memory-side outputs: mem_address (ADDR_W), mem_chipselect (1), mem_write (1), mem_writedata (DATA_W), mem_byteenable (BE_W), mem_clken (1).
REQ-011 The block SHALL have mem_readdata, input, DATA_W: the memory's unregistered q_b.

Function
REQ-012 A master SHALL be requesting when mN_read or mN_write is 1; if both are 1, the access SHALL be treated as a write.
REQ-013 mem_clken SHALL equal ~reset_req, combinationally.
REQ-014 Grant SHALL be decided combinationally in the same cycle:
- one requester: that master wins;
- two requesters: the master not equal to register last_grant wins.
REQ-015 A transfer SHALL be accepted when a master is granted and reset_req is 0; last_grant SHALL load the accepted master index on the next clk edge.
REQ-016 mN_waitrequest SHALL equal mN requesting AND NOT (mN accepted this cycle).
REQ-017 mem_chipselect SHALL equal "any transfer accepted"; mem_write SHALL equal accepted AND the access is a write.
REQ-018 mem_address, mem_writedata and mem_byteenable SHALL be muxed from the granted master; they SHALL be all-zero when no transfer is accepted.
REQ-019 Read latency SHALL be exactly 1 cycle:
- on an accepted read, register rd_pending SHALL set to 1 and register rd_owner SHALL take the master index;
- in the next cycle, m[rd_owner]_readdatavalid SHALL be 1 and m[rd_owner]_readdata SHALL equal mem_readdata.
REQ-020 The non-owner's readdata SHALL be 0 and its readdatavalid SHALL be 0.
REQ-021 Back-to-back reads (one per cycle, either master, alternating allowed) SHALL be fully pipelined with no bubble.
REQ-022 If reset_req rises in the cycle after an accepted read, that read's readdatavalid SHALL still be delivered; no new transfer SHALL be accepted while reset_req is 1.
REQ-023 Write then read to the same address in consecutive cycles SHALL return the new data (ordering is preserved by single-port serialization).
REQ-024 A master that holds its request SHALL be granted within 2 cycles of reset_req being 0 (no starvation).

Reset
REQ-025 On reset_n = 0 the block SHALL asynchronously set last_grant = 1 (master 0 wins the first conflict), rd_pending = 0 and rd_owner = 0.
REQ-026 During reset, all readdatavalid outputs SHALL be 0, all readdata outputs SHALL be 0, and mem_chipselect and mem_write SHALL be 0.
REQ-027 During reset, waitrequest SHALL still follow REQ-016; no transfer SHALL be accepted until reset_n is sampled high.
REQ-028 Reset asserted with a read pending SHALL drop the read; no readdatavalid SHALL appear after reset release.

Structure
REQ-029 ADDR_W, DATA_W and BE_W defaults, and a 1-bit master-index type, SHALL reside in shared package dircc_proc_mem_pkg.
REQ-030 The two-way round-robin grant logic, including last_grant, SHALL be sub-module dircc_rr_arbiter2; the datapath muxing and read tracking SHALL remain in the top-level module.

Verification
REQ-031 Single master: m0 writes 0xBEEF to 0x0010 with be=2'b11, then reads 0x0010 -> no waitrequest on either access; m0_readdatavalid=1 one cycle after the read with m0_readdata=0xBEEF.
REQ-032 Simultaneous reads after reset (m0@0x0001, m1@0x0002) -> cycle 0: m0 granted, m1_waitrequest=1; cycle 1: m1 granted and m0_readdatavalid=1; cycle 2: m1_readdatavalid=1.
REQ-033 Both masters hold continuous requests for 8 cycles -> grants alternate 0,1,0,1,...; each master is granted exactly 4 times.
REQ-034 reset_req=1 for 3 cycles while both masters request -> mem_clken=0 and mem_chipselect=0; both waitrequests=1; a read accepted just before the hold-off still returns readdatavalid.
REQ-035 Byte write: write 0x1234 with be=2'b01 over 0xFFFF -> a subsequent read returns 0xFF34.
REQ-036 reset_n pulsed low with a read pending -> no readdatavalid appears; the first post-reset conflict is granted to m0.
